shift_writeback: RTL and testbench
==================================

SHIFT_WRITEBACK -- requirements
Module: shift_writeback

Interface
REQ-001 SHALL have parameter DATA_W, default 8, datapath width.
REQ-002 SHALL have parameter RF_AW, default 3, register-file address width.
REQ-003 clk  input  1  sole clock, rising edge; one clock, reset is asynchronous and active-low.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  shifter result presented.
REQ-006 in_ready  output  1  stage can accept; equals NOT full.
REQ-007 in_data  input  DATA_W  shifter output.
REQ-008 in_src  input  DATA_W  pre-shift operand, used for carry.
REQ-009 in_op  input  3  shift op: 000 LSL, 001 LSR, 010 RSR, 011 RSL, 100 ASR, 101-111 illegal.
REQ-010 in_shamt  input  3  shift amount 0-7.
REQ-011 in_imm  input  1  immediate pass-through; no shift performed.
REQ-012 in_rd  input  RF_AW  destination register.
REQ-013 rf_we / rf_waddr / rf_wdata  output  1/RF_AW/DATA_W  register-file write port.
REQ-014 rf_ready  input  1  register file accepts write this cycle.
REQ-015 flags  output  3  {N,Z,C} status register.
REQ-016 illegal  output  1  sticky illegal-op indication.

Function
REQ-017 SHALL accept an entry on a cycle with in_valid AND in_ready, storing data, rd, op, imm and computed carry into a 2-entry FIFO.
REQ-018 Carry SHALL be: LSL k>0 -> in_src[DATA_W-k]; LSR/ASR k>0 -> in_src[k-1]; RSR k>0 -> in_data[DATA_W-1]; RSL k>0 -> in_data[0]; k=0 or in_imm=1 -> C unchanged.
REQ-019 Head entry SHALL drive rf_we=1 (legal op), rf_waddr, rf_wdata; entry retires on rf_we AND rf_ready.
REQ-020 On retire, flags SHALL update: N=data MSB, Z=(data==0), C per REQ-018.
REQ-021 Illegal-op entries SHALL retire one cycle after reaching head with rf_we=0, flags unchanged, illegal set to 1 until reset.
REQ-022 Without bypass, minimum accept-to-rf_we latency SHALL be 1 cycle; rf_we SHALL be held with stable address/data until rf_ready.
REQ-023 Simultaneous push and retire with 1 entry SHALL keep count at 1 with order preserved; when full (2), in_ready=0 and in_valid SHALL be ignored.
REQ-024 Empty FIFO SHALL drive rf_we=0; rf_waddr and rf_wdata SHALL hold last values.

Reset
REQ-025 On rst_n low, asynchronously: FIFO count 0, pointers 0, rf_we=0, rf_waddr=0, rf_wdata=0, flags=000, illegal=0; in_ready=1 after release.
REQ-026 Reset mid-operation SHALL discard all buffered entries without any write.

Configuration
REQ-027 Macro SHIFT_WRITEBACK_BYPASS_EN: defined -> when FIFO empty, rf_ready=1 and a legal entry is accepted, it SHALL be written the same cycle (zero latency) and flags updated at that edge, never entering the FIFO.
REQ-028 Undefined -> every entry SHALL pass through the FIFO (REQ-022 latency).

Structure
REQ-029 Shared package cpu_pkg SHALL hold the shift-op enum (LSL, LSR, RSR, RSL, ASR) and the {N,Z,C} flag struct.
REQ-030 The 2-entry FIFO SHALL be sub-module shift_wb_fifo; carry logic and flag register stay in shift_writeback.

Verification
REQ-031 LSL k=1, in_src=0x81, in_data=0x02, rd=3, rf_ready=1 -> rf_we, waddr 3, wdata 0x02; flags N=0 Z=0 C=1.
REQ-032 ASR k=3, in_src=0x80, in_data=0xF0 -> wdata 0xF0; N=1 Z=0 C=0.
REQ-033 rf_ready=0, push 3 back-to-back entries -> in_ready low after 2nd; 3rd not taken; rf_ready=1 releases entries in order.
REQ-034 in_op=101, in_data=0x00 -> no rf_we, flags unchanged, illegal=1 until reset.
REQ-035 Assert rst_n low with 2 entries buffered -> rf_we=0 immediately; no writes after release; flags=000.
REQ-036 LSR k=0, in_data=0x00, C previously 1 -> Z=1, N=0, C stays 1; with bypass macro, rf_we in acceptance cycle.

Source files
------------

// File: rtl/shift_writeback_pkg.sv
// Shared CPU definitions: shift-op encoding, {N,Z,C} flag struct and an op legality helper.
package cpu_pkg;

  typedef enum logic [2:0] {
    OP_LSL = 3'b000,
    OP_LSR = 3'b001,
    OP_RSR = 3'b010,
    OP_RSL = 3'b011,
    OP_ASR = 3'b100
  } shift_op_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
  } flags_t;

  // Encodings 101..111 are reserved and treated as illegal.
  function automatic logic op_legal(input logic [2:0] op);
    return op <= 3'd4;
  endfunction

endpackage

// File: rtl/shift_writeback_if.sv
// Shifter-result input handshake plus register-file write port, bundled for shift_writeback.
interface shift_writeback_if #(
  parameter int DATA_W = 8,
  parameter int RF_AW  = 3
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [DATA_W-1:0] in_src;
  logic [2:0]        in_op;
  logic [2:0]        in_shamt;
  logic              in_imm;
  logic [RF_AW-1:0]  in_rd;
  logic              rf_we;
  logic [RF_AW-1:0]  rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              rf_ready;

  modport master (
    output in_valid, in_data, in_src, in_op, in_shamt, in_imm, in_rd, rf_ready,
    input  in_ready, rf_we, rf_waddr, rf_wdata
  );

  modport slave (
    input  in_valid, in_data, in_src, in_op, in_shamt, in_imm, in_rd, rf_ready,
    output in_ready, rf_we, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/shift_writeback_fifo.sv
// Two-entry FIFO (module shift_wb_fifo) holding packed writeback entries; head is read combinationally.
module shift_wb_fifo #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         push_ok, pop_ok;

  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  assign head_o  = mem_q[rd_ptr_q];

  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = ~wr_ptr_q;
    if (pop_ok)  rd_ptr_d = ~rd_ptr_q;
    count_d = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/shift_writeback.sv
// Shifter writeback stage: carry capture, 2-entry buffer, register-file write and {N,Z,C}/illegal status.
// Optional zero-latency bypass when empty is enabled by defining SHIFT_WRITEBACK_BYPASS_EN.
module shift_writeback
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int RF_AW  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  shift_writeback_if.slave  bus,
  output logic [2:0]        flags,
  output logic              illegal
);

  localparam int ENT_W = 3 + 1 + 1 + 1 + RF_AW + DATA_W;

  logic              empty, full, push, pop, bypass, wr_fire;
  logic [ENT_W-1:0]  ent_in, head;
  logic [2:0]        head_op;
  logic              head_imm, head_knz, head_carry, head_legal;
  logic [RF_AW-1:0]  head_rd;
  logic [DATA_W-1:0] head_data;
  logic              in_knz, carry_in;
  logic [DATA_W-1:0] lsl_shr, lsr_shr;
  logic [RF_AW-1:0]  src_rd;
  logic [DATA_W-1:0] src_data;
  logic              src_cupd, src_carry;

  flags_t            flags_q, flags_d;
  logic              illegal_q, illegal_d;
  logic [RF_AW-1:0]  waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  // Bring the last bit shifted out down to bit 0 for the left/right shift cases.
  assign lsl_shr = bus.in_src >> (DATA_W - int'(bus.in_shamt));
  assign lsr_shr = bus.in_src >> (bus.in_shamt - 3'd1);
  assign in_knz  = (bus.in_shamt != 3'd0);

  always_comb begin
    carry_in = 1'b0;
    case (bus.in_op)
      OP_LSL:         carry_in = lsl_shr[0];
      OP_LSR, OP_ASR: carry_in = lsr_shr[0];
      OP_RSR:         carry_in = bus.in_data[DATA_W-1];
      OP_RSL:         carry_in = bus.in_data[0];
      default:        carry_in = 1'b0;
    endcase
  end

  assign ent_in = {bus.in_op, bus.in_imm, in_knz, carry_in, bus.in_rd, bus.in_data};
  assign {head_op, head_imm, head_knz, head_carry, head_rd, head_data} = head;
  assign head_legal = op_legal(head_op);

`ifdef SHIFT_WRITEBACK_BYPASS_EN
  assign bypass = empty & bus.in_valid & op_legal(bus.in_op) & bus.rf_ready;
`else
  assign bypass = 1'b0;
`endif

  assign bus.in_ready = ~full;
  assign push         = bus.in_valid & bus.in_ready & ~bypass;
  // Illegal heads drain unconditionally; legal heads wait for the register file.
  assign pop          = ~empty & (head_legal ? bus.rf_ready : 1'b1);

  shift_wb_fifo #(.W(ENT_W)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (ent_in),
    .full_o  (full),
    .empty_o (empty),
    .head_o  (head)
  );

  assign src_rd    = bypass ? bus.in_rd   : head_rd;
  assign src_data  = bypass ? bus.in_data : head_data;
  assign src_cupd  = bypass ? (~bus.in_imm & in_knz) : (~head_imm & head_knz);
  assign src_carry = bypass ? carry_in    : head_carry;

  assign bus.rf_we    = bypass | (~empty & head_legal);
  assign bus.rf_waddr = bus.rf_we ? src_rd   : waddr_q;
  assign bus.rf_wdata = bus.rf_we ? src_data : wdata_q;
  assign wr_fire      = bus.rf_we & bus.rf_ready;

  always_comb begin
    flags_d   = flags_q;
    illegal_d = illegal_q | (pop & ~head_legal);
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    if (wr_fire) begin
      flags_d.n = src_data[DATA_W-1];
      flags_d.z = (src_data == '0);
      if (src_cupd) flags_d.c = src_carry;
      waddr_d = src_rd;
      wdata_d = src_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q   <= '0;
      illegal_q <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
    end else begin
      flags_q   <= flags_d;
      illegal_q <= illegal_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign flags   = flags_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_shift_writeback.sv
// Self-checking bench for shift_writeback against a queue-based reference model (bypass-aware).
module tb_shift_writeback;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] flags;
  logic       illegal;

  shift_writeback_if #(.DATA_W(8), .RF_AW(3)) bus();

  shift_writeback #(.DATA_W(8), .RF_AW(3)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .flags   (flags),
    .illegal (illegal)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [7:0] data;
    logic [2:0] rd;
    bit         legal;
    bit         cupd;
    bit         carry;
  } ent_t;

  ent_t       q[$];
  logic [2:0] m_flags;
  bit         m_ill;
  logic [2:0] m_addr;
  logic [7:0] m_data;

  task automatic model_reset();
    q.delete();
    m_flags = 3'b000;
    m_ill   = 1'b0;
    m_addr  = 3'd0;
    m_data  = 8'd0;
  endtask

  function automatic ent_t make_ent();
    ent_t e;
    int   k = int'(bus.in_shamt);
    int   s = int'(bus.in_src);
    int   d = int'(bus.in_data);
    e.data  = bus.in_data;
    e.rd    = bus.in_rd;
    e.legal = bus.in_op < 3'd5;
    e.cupd  = e.legal && !bus.in_imm && k != 0;
    e.carry = 1'b0;
    case (int'(bus.in_op))
      0:       e.carry = ((s >> (8 - k)) & 1) != 0;
      1, 4:    e.carry = ((s >> (k - 1)) & 1) != 0;
      2:       e.carry = d >= 128;
      3:       e.carry = (d % 2) == 1;
      default: e.carry = 1'b0;
    endcase
    return e;
  endfunction

  function automatic logic [16:0] expected();
    logic       we = 1'b0;
    logic [2:0] a  = m_addr;
    logic [7:0] d  = m_data;
    if (q.size() > 0) begin
      if (q[0].legal) begin
        we = 1'b1; a = q[0].rd; d = q[0].data;
      end
    end
`ifdef SHIFT_WRITEBACK_BYPASS_EN
    else if (bus.in_valid && bus.in_op < 3'd5 && bus.rf_ready) begin
      we = 1'b1; a = bus.in_rd; d = bus.in_data;
    end
`endif
    return {q.size() < 2, we, a, d, m_flags, m_ill};
  endfunction

  function automatic logic [16:0] observed();
    return {bus.in_ready, bus.rf_we, bus.rf_waddr, bus.rf_wdata, flags, illegal};
  endfunction

  task automatic apply_write(input ent_t e);
    m_flags[2] = e.data[7];
    m_flags[1] = (e.data == 8'd0);
    if (e.cupd) m_flags[0] = e.carry;
    m_addr = e.rd;
    m_data = e.data;
    $display("write rd=%0d data=0x%02h flags=%03b", e.rd, e.data, m_flags);
  endtask

  // Advance the model by one clock using the inputs currently applied, then step the DUT.
  task automatic tick();
    ent_t e   = make_ent();
    bit   acc = bus.in_valid && q.size() < 2;
    bit   byp = 1'b0;
`ifdef SHIFT_WRITEBACK_BYPASS_EN
    byp = acc && q.size() == 0 && e.legal && bus.rf_ready;
`endif
    if (byp) begin
      apply_write(e);
    end else begin
      if (q.size() > 0) begin
        if (!q[0].legal) begin
          void'(q.pop_front());
          m_ill = 1'b1;
          $display("retire illegal entry rd=%0d", e.rd);
        end else if (bus.rf_ready) begin
          apply_write(q.pop_front());
        end
      end
      if (acc) q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input bit [2:0] op, input bit [2:0] k, input bit imm,
                       input bit [7:0] src, input bit [7:0] data, input bit [2:0] rd, input bit rr);
    bus.in_valid = v;   bus.in_op   = op;  bus.in_shamt = k;  bus.in_imm = imm;
    bus.in_src   = src; bus.in_data = data; bus.in_rd   = rd; bus.rf_ready = rr;
  endtask

  task automatic test_reset();
    drive(0, 3'd0, 3'd0, 0, 8'h00, 8'h00, 3'd0, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata, flags, illegal} !== 16'd0)
      $display("FAIL reset_state: got we=%b addr=%0d data=%h flags=%b ill=%b, want all zero",
               bus.rf_we, bus.rf_waddr, bus.rf_wdata, flags, illegal);
    else n_pass++;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", bus.in_ready);
    else n_pass++;
  endtask

  task automatic test_directed();
    bit [2:0] t_op[4]    = '{3'd4, 3'd0, 3'd1, 3'd5};
    bit [2:0] t_k[4]     = '{3'd3, 3'd1, 3'd0, 3'd0};
    bit [7:0] t_src[4]   = '{8'h80, 8'h81, 8'h00, 8'h00};
    bit [7:0] t_data[4]  = '{8'hF0, 8'h02, 8'h00, 8'h00};
    bit [2:0] t_rd[4]    = '{3'd1, 3'd3, 3'd5, 3'd6};
    bit [2:0] t_flags[4] = '{3'b100, 3'b001, 3'b011, 3'b011};
    bit       t_ill[4]   = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      for (int c = 0; c < 3; c++) begin
        if (c == 0) drive(1, t_op[i], t_k[i], 0, t_src[i], t_data[i], t_rd[i], 1);
        else        drive(0, 3'd0, 3'd0, 0, 8'h00, 8'h00, 3'd0, 1);
        @(negedge clk);
        n_checks++;
        if (observed() !== expected())
          $display("FAIL directed_%0d_cyc%0d: got %h want %h", i, c, observed(), expected());
        else n_pass++;
        tick();
      end
      n_checks++;
      if (flags !== t_flags[i] || illegal !== t_ill[i])
        $display("FAIL directed_flags_%0d: got flags=%b ill=%b want flags=%b ill=%b",
                 i, flags, illegal, t_flags[i], t_ill[i]);
      else n_pass++;
      if (!t_ill[i]) begin
        n_checks++;
        if (bus.rf_waddr !== t_rd[i] || bus.rf_wdata !== t_data[i])
          $display("FAIL directed_hold_%0d: got addr=%0d data=%h want addr=%0d data=%h",
                   i, bus.rf_waddr, bus.rf_wdata, t_rd[i], t_data[i]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_back_to_back();
    int writes = 0;
    for (int i = 0; i < 3; i++) begin
      drive(1, 3'(i), 3'd2, 0, 8'($urandom), 8'($urandom), 3'(i + 1), 0);
      @(negedge clk);
      n_checks++;
      if (observed() !== expected())
        $display("FAIL b2b_push_%0d: got %h want %h", i, observed(), expected());
      else n_pass++;
      if (i == 2) begin
        n_checks++;
        if (bus.in_ready !== 1'b0) $display("FAIL b2b_full_ready: got %b want 0", bus.in_ready);
        else n_pass++;
      end
      tick();
    end
    for (int c = 0; c < 4; c++) begin
      drive(0, 3'd0, 3'd0, 0, 8'h00, 8'h00, 3'd0, 1);
      @(negedge clk);
      if (bus.rf_we === 1'b1) writes++;
      n_checks++;
      if (observed() !== expected())
        $display("FAIL b2b_drain_%0d: got %h want %h", c, observed(), expected());
      else n_pass++;
      tick();
    end
    n_checks++;
    if (writes != 2) $display("FAIL b2b_write_count: got %0d want 2", writes);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 200; c++) begin
      int r = int'($urandom_range(0, 15));
      bit [2:0] op = (r < 13) ? 3'(r % 5) : 3'(r - 8);
      drive(1'($urandom_range(0, 3) != 0), op, 3'($urandom), 1'($urandom_range(0, 5) == 0),
            8'($urandom), 8'($urandom_range(0, 7) == 0 ? 0 : $urandom), 3'($urandom),
            1'($urandom_range(0, 2) != 0));
      @(negedge clk);
      n_checks++;
      if (observed() !== expected())
        $display("FAIL random_%0d: got %h want %h", c, observed(), expected());
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_reset_mid();
    int writes = 0;
    for (int c = 0; c < 5; c++) begin
      if (c < 3) drive(0, 3'd0, 3'd0, 0, 8'h00, 8'h00, 3'd0, 1);
      else       drive(1, 3'd0, 3'd1, 0, 8'hFF, 8'(8'h40 + c), 3'(c), 0);
      @(negedge clk);
      n_checks++;
      if (observed() !== expected())
        $display("FAIL rstmid_fill_%0d: got %h want %h", c, observed(), expected());
      else n_pass++;
      tick();
    end
    drive(0, 3'd0, 3'd0, 0, 8'h00, 8'h00, 3'd0, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata, flags, illegal} !== 16'd0)
      $display("FAIL rstmid_async: got we=%b addr=%0d data=%h flags=%b ill=%b, want all zero",
               bus.rf_we, bus.rf_waddr, bus.rf_wdata, flags, illegal);
    else n_pass++;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.rf_we === 1'b1) writes++;
      n_checks++;
      if (observed() !== expected())
        $display("FAIL rstmid_after_%0d: got %h want %h", c, observed(), expected());
      else n_pass++;
      tick();
    end
    n_checks++;
    if (writes != 0) $display("FAIL rstmid_no_writes: got %0d writes want 0", writes);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
